// File: rtl/led_bank_arb.sv
// led_bank_arb -- arbitrates one 5-bit LED bank between four requesters.
//
// A free-running prescaler produces a slow tick. Requesters are served
// round-robin. An owner keeps the bank for at least HOLD_TICKS ticks.
// After that it is preempted only when some other requester is waiting.
// A one-cycle blank (GAP) separates consecutive owners. An owner that
// drops its request releases the bank at once; release wins over
// preemption when both occur in the same cycle.
//
// Parameters
//   PRESC_W     tick period is 2^PRESC_W clocks
//   HOLD_TICKS  minimum ownership in ticks before preemption (1..255)
//
// Ports
//   clk_25mhz  in   sole clock, rising edge
//   rstn       in   synchronous active-low reset
//   req   [3:0]  in   request level per requester
//   pat  [19:0]  in   pat[5i+4:5i] is the LED pattern of requester i
//   grant [3:0]  out  registered one-hot owner, zero when there is no owner
//   led   [4:0]  out  registered LED drive
//   tick         out  registered one-cycle prescaler pulse
//   state_o [1:0] out FSM state for debug (0=IDLE, 1=OWN, 2=GAP)
//
// Handshake: req is a level, not a pulse. A requester that keeps req high
// and sees its grant bit set owns the bank until it drops req or is
// preempted. grant follows the cycle after req is sampled; led follows
// the owner's pattern with one cycle of latency.
module led_bank_arb #(
  parameter int PRESC_W    = 20,
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk_25mhz,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [19:0] pat,
  output logic [3:0]  grant,
  output logic [4:0]  led,
  output logic        tick,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  logic [7:0]         hold_q, hold_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         grant_q, grant_d;
  logic [4:0]         led_q, led_d;

  logic [1:0] cand;
  logic [1:0] winner;
  logic       win_valid;
  logic [1:0] sel_idx;
  logic [4:0] sel_pat;
  logic [3:0] owner_mask;

  // Prescaler. tick_q is high in the cycle after the counter sits at its
  // maximum value, so the pulse is already registered.
  always_ff @(posedge clk_25mhz) begin
    if (!rstn) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
      tick_q  <= &presc_q;
    end
  end

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself. The
  // previous owner therefore wins only when it is the sole requester.
  always_comb begin
    win_valid = 1'b0;
    winner    = ptr_q;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // In OWN the pattern comes from the current owner. On entry to OWN it
  // comes from the new winner.
  always_comb begin
    sel_idx = (state_q == ST_OWN) ? ptr_q : winner;
    case (sel_idx)
      2'd0:    sel_pat = pat[4:0];
      2'd1:    sel_pat = pat[9:5];
      2'd2:    sel_pat = pat[14:10];
      default: sel_pat = pat[19:15];
    endcase
  end

  assign owner_mask = 4'b0001 << ptr_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        // Both states blank the bank and start a fresh ownership when any
        // request is present.
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        led_d   = 5'b00000;
        hold_d  = 8'd0;
        if (win_valid) begin
          state_d = ST_OWN;
          grant_d = 4'b0001 << winner;
          ptr_d   = winner;
          led_d   = sel_pat;
        end
      end
      ST_OWN: begin
        if (!req[ptr_q]) begin
          // Release takes priority over preemption.
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          led_d   = 5'b00000;
        end else if (hold_q == HOLD_MAX && (req & ~owner_mask) != 4'b0000) begin
          state_d = ST_GAP;
          grant_d = 4'b0000;
          led_d   = 5'b00000;
        end else begin
          led_d = sel_pat;
          if (tick_q && hold_q != HOLD_MAX) begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        led_d   = 5'b00000;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      led_q   <= 5'b00000;
      hold_q  <= 8'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant   = grant_q;
  assign led     = led_q;
  assign tick    = tick_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_led_bank_arb.sv
// Testbench for led_bank_arb with PRESC_W=2 and HOLD_TICKS=2.
// Each vector holds the inputs for one clock edge and the outputs expected
// after that edge. The tick expectation comes from the bench's own count of
// edges since reset release.
module tb_led_bank_arb;

  localparam int PRESC_W    = 2;
  localparam int HOLD_TICKS = 2;
  localparam int TICK_PER   = 1 << PRESC_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic        clk_25mhz = 1'b0;
  logic        rstn      = 1'b0;
  logic [3:0]  req       = 4'b0000;
  logic [19:0] pat       = 20'd0;
  logic [3:0]  grant;
  logic [4:0]  led;
  logic        tick;
  logic [1:0]  state_o;

  // Clock and reset: a 40 ns period; reset is applied through the vectors.
  always #20 clk_25mhz = ~clk_25mhz;

  led_bank_arb #(
    .PRESC_W   (PRESC_W),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rstn     (rstn),
    .req      (req),
    .pat      (pat),
    .grant    (grant),
    .led      (led),
    .tick     (tick),
    .state_o  (state_o)
  );

  typedef struct {
    int          scen;
    logic        rstn;
    logic [3:0]  req;
    logic [19:0] pat;
    logic [3:0]  exp_grant;
    logic [4:0]  exp_led;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];   // {state, tick, grant, led}
  int          checks = 0;
  int          errors = 0;
  string       scen_name[7] = '{"reset_idle", "single_owner", "round_robin",
                                "release_vs_preempt", "reset_mid_own",
                                "reset_mid_gap", "pattern_track"};

  function automatic logic [19:0] rand_pat();
    return 20'($urandom_range(0, (1 << 20) - 1));
  endfunction

  function automatic logic [19:0] set_slice(input logic [19:0] p, input int i,
                                            input logic [4:0] v);
    logic [19:0] r;
    r = p;
    r[5*i +: 5] = v;
    return r;
  endfunction

  // Expected led is the owner's pattern slice, or zero without an owner.
  task automatic add(input int scen, input logic r, input logic [3:0] q,
                     input logic [19:0] p, input logic [3:0] g, input logic gap);
    vec_t v;
    v.scen      = scen;
    v.rstn      = r;
    v.req       = q;
    v.pat       = p;
    v.exp_grant = g;
    v.exp_led   = 5'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) v.exp_led = p[5*i +: 5];
    end
    v.exp_state = (g != 4'b0000) ? ST_OWN : (gap ? ST_GAP : ST_IDLE);
    vecs.push_back(v);
  endtask

  task automatic add_reset(input int scen, input int cycles);
    for (int i = 0; i < cycles; i++) add(scen, 1'b0, 4'b0000, rand_pat(), 4'b0000, 1'b0);
  endtask

  task automatic check(input int k, input string what, input logic [4:0] got,
                       input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d %s: got %b expected %b",
               scen_name[vecs[k].scen], k, what, got, exp);
    end
  endtask

  // Scoreboard: compare the oldest expected word with the DUT outputs.
  task automatic compare(input int k);
    logic [11:0] w;
    w = exp_q.pop_front();
    check(k, "state", {3'b000, state_o}, {3'b000, w[11:10]});
    check(k, "tick",  {4'b0000, tick},   {4'b0000, w[9]});
    check(k, "grant", {1'b0, grant},     {1'b0, w[8:5]});
    check(k, "led",   led,               w[4:0]);
    checks++;
    if ($countones(grant) > 1) begin
      errors++;
      $display("FAIL %s vec %0d grant_onehot: got %b expected at most one bit",
               scen_name[vecs[k].scen], k, grant);
    end
  endtask

  initial begin
    logic [19:0] p;
    logic [19:0] p2;
    logic [3:0]  g;
    int          n;

    // Scenario 0: reset, then idle with no requests.
    add_reset(0, 3);
    for (int i = 0; i < 8; i++) add(0, 1'b1, 4'b0000, rand_pat(), 4'b0000, 1'b0);

    // Scenario 1: single owner holds for 40 cycles; hold_cnt saturates, so
    // a late competitor preempts at once; then release.
    p = set_slice(rand_pat(), 0, 5'b10101);
    add(1, 1'b1, 4'b0001, p, 4'b0001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      add(1, 1'b1, 4'b0001, set_slice(rand_pat(), 0, 5'b10101), 4'b0001, 1'b0);
    end
    add(1, 1'b1, 4'b0011, rand_pat(), 4'b0000, 1'b1);
    add(1, 1'b1, 4'b0011, rand_pat(), 4'b0010, 1'b0);
    add(1, 1'b1, 4'b0000, rand_pat(), 4'b0000, 1'b0);
    add(1, 1'b1, 4'b0000, rand_pat(), 4'b0000, 1'b0);

    // Scenario 2: all four request from reset. Ticks follow edges 3,7,11..;
    // each owner reaches hold 2 at its second tick, and a GAP follows.
    add_reset(2, 2);
    for (int e = 0; e <= 34; e++) begin
      if (e == 9 || e == 17 || e == 25 || e == 33) g = 4'b0000;
      else if (e <= 8)  g = 4'b0001;
      else if (e <= 16) g = 4'b0010;
      else if (e <= 24) g = 4'b0100;
      else if (e <= 32) g = 4'b1000;
      else              g = 4'b0001;
      add(2, 1'b1, 4'b1111, rand_pat(), g, g == 4'b0000);
    end
    add(2, 1'b1, 4'b0000, rand_pat(), 4'b0000, 1'b0);

    // Scenario 3: owner 0 with others toggling; it drops its request in the
    // very cycle hold_cnt reaches 2, so the bank goes IDLE, not GAP.
    add_reset(3, 2);
    add(3, 1'b1, 4'b0001, rand_pat(), 4'b0001, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      add(3, 1'b1, {3'($urandom_range(0, 7)), 1'b1}, rand_pat(), 4'b0001, 1'b0);
    end
    add(3, 1'b1, 4'b0010, rand_pat(), 4'b0000, 1'b0);
    add(3, 1'b1, 4'b0010, rand_pat(), 4'b0010, 1'b0);
    add(3, 1'b1, 4'b0010, rand_pat(), 4'b0010, 1'b0);

    // Scenario 4: reset while owner 2 drives 11111; ptr restarts at 3.
    add_reset(4, 2);
    p = set_slice(rand_pat(), 2, 5'b11111);
    for (int i = 0; i < 3; i++) add(4, 1'b1, 4'b0100, p, 4'b0100, 1'b0);
    add(4, 1'b0, 4'b0100, p, 4'b0000, 1'b0);
    add(4, 1'b1, 4'b0110, rand_pat(), 4'b0010, 1'b0);
    add(4, 1'b1, 4'b0110, rand_pat(), 4'b0010, 1'b0);

    // Scenario 5: reset during GAP; requester 0 wins again instead of 1.
    add_reset(5, 2);
    for (int i = 0; i <= 8; i++) add(5, 1'b1, 4'b1111, rand_pat(), 4'b0001, 1'b0);
    add(5, 1'b1, 4'b1111, rand_pat(), 4'b0000, 1'b1);
    add(5, 1'b0, 4'b1111, rand_pat(), 4'b0000, 1'b0);
    add(5, 1'b1, 4'b1111, rand_pat(), 4'b0001, 1'b0);
    add(5, 1'b1, 4'b1111, rand_pat(), 4'b0001, 1'b0);

    // Scenario 6: owner 3 pattern 00001 -> 11000 shows up one edge later.
    add_reset(6, 2);
    p  = set_slice(rand_pat(), 3, 5'b00001);
    p2 = set_slice(p, 3, 5'b11000);
    for (int i = 0; i < 3; i++) add(6, 1'b1, 4'b1000, p, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) add(6, 1'b1, 4'b1000, p2, 4'b1000, 1'b0);

    // Driver: apply each vector, push its expectation, compare after the edge.
    n = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      logic exp_tick;
      rstn = vecs[k].rstn;
      req  = vecs[k].req;
      pat  = vecs[k].pat;
      exp_tick = vecs[k].rstn && ((n % TICK_PER) == TICK_PER - 1);
      exp_q.push_back({vecs[k].exp_state, exp_tick, vecs[k].exp_grant, vecs[k].exp_led});
      @(posedge clk_25mhz);
      #1;
      n = vecs[k].rstn ? n + 1 : 0;
      compare(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
